up_down_mod_counter: RTL
========================

Name: up_down_mod_counter

Overview:
Parametrised modulo-N up/down counter, the next generation of the team's 4-bit free-running up counter. Adds configurable width and modulus, direction control, enable, parallel load, a wrap/saturate mode, a clock-enable prescaler, and terminal-count/wrap status outputs. Used as the general-purpose event/timebase counter in datapath and control blocks.

Parameters:
WIDTH, 4, bit width of count and load_val
MODULUS, 16, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value
RESET_VAL, 0, count value after reset; must be < MODULUS
PRESCALE, 1, number of enabled cycles per count step; must be >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; advances the prescaler
up_dn  input  1  1 = count up, 0 = count down; sampled on the step cycle
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  current count, registered
tc  output  1  terminal count: combinational (up_dn ? count==MODULUS-1 : count==0)
wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap step

Behaviour:
- One clock (clk). Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: count=RESET_VAL, wrap=0, prescaler=0. tc follows from count and up_dn.
- Priority each edge: reset > load > step > hold.
- Load: count <= load_val if load_val < MODULUS, else MODULUS-1 (clamp). Prescaler cleared to 0; wrap=0. Load overrides en in the same cycle.
- Prescaler: internal counter 0..PRESCALE-1. It increments on each cycle with en=1 and wraps to 0. It holds when en=0. A step occurs on a cycle with en=1 and prescaler==PRESCALE-1. With PRESCALE=1, every enabled cycle is a step.
- Step, up (up_dn=1):
  - count < MODULUS-1: count+1.
  - count == MODULUS-1 and SATURATE=0: count becomes 0; wrap=1 next cycle.
  - count == MODULUS-1 and SATURATE=1: count holds; wrap=0.
- Step, down (up_dn=0):
  - count > 0: count-1.
  - count == 0 and SATURATE=0: count becomes MODULUS-1; wrap=1.
  - count == 0 and SATURATE=1: count holds; wrap=0.
- wrap is 0 on every cycle that is not a wrap step. Back-to-back wrap steps (e.g. MODULUS=2, PRESCALE=1) keep wrap high continuously.
- Direction changes between steps are legal. Only up_dn at the step edge matters, and the prescaler is not cleared.
- Arithmetic: compare against MODULUS-1 using WIDTH+1-bit constants, so that MODULUS=2**WIDTH does not overflow. No intermediate value exceeds MODULUS-1.
- Reset asserted mid-prescale or mid-count returns all state to reset values on that edge. No residual wrap pulse.
- Elaboration-time checks (generate-time error) for illegal MODULUS, RESET_VAL and PRESCALE.
- Latency: count updates on the edge of the step or load cycle; tc is valid in the same cycle as count.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants.
  - Function clog2 for sizing the prescaler.
  - Function clamp_to_mod(value, modulus) used by load.
- One natural sub-module: counter_prescaler.
  - Parameter PRESCALE; inputs clk, reset, en, clear; output step.
  - Instantiated once; with PRESCALE=1 it reduces to step=en.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1, SATURATE=0; reset, then en=1, up_dn=1 for 12 cycles -> count 1..9, 0, 1, 2; wrap high exactly one cycle after count returns to 0; tc high while count==9.
- Same config, up_dn=0 from count=0 -> count 9, 8, 7; wrap pulses once; tc high at count==0 before the step.
- SATURATE=1, MODULUS=10: load 8, count up 4 steps -> 9, 9, 9, 9, wrap never asserted. Then down from 0 -> holds at 0.
- Load and en both asserted with load_val=13, MODULUS=10 -> count=9 (clamped); next enabled up step -> 0 with wrap=1.
- PRESCALE=3, MODULUS=16: en toggling 1,1,0,1,1,1 -> count increments only on the 3rd and 6th enabled cycles, i.e. after 4 and 7 clocks; en=0 freezes the prescaler.
- Assert reset for one cycle at count=5 with prescaler=1 and wrap pending -> next cycle count=RESET_VAL, wrap=0, a full PRESCALE enabled cycles needed before the next step.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < longint'(value)) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned clamp_to_mod(input int unsigned value,
                                                 input int unsigned modulus);
        return (value < modulus) ? value : modulus - 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one step per PRESCALE enabled cycles.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic step
);

    if (PRESCALE <= 1) begin : gen_bypass
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset, clear};
        assign step          = en;
    end else begin : gen_divide
        localparam int unsigned PW = clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] phase_q;
        logic [PW-1:0] phase_d;

        assign step = en && (phase_q == LAST);

        always_comb begin
            phase_d = phase_q;
            if (clear) begin
                phase_d = '0;
            end else if (en) begin
                phase_d = step ? '0 : phase_q + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// Modulo-N up/down counter with load, wrap/saturate mode, prescaler and status outputs.
module up_down_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : gen_bad_modulus
        $error("up_down_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : gen_bad_reset_val
        $error("up_down_mod_counter: RESET_VAL must be below MODULUS");
    end
    if (PRESCALE < 1) begin : gen_bad_prescale
        $error("up_down_mod_counter: PRESCALE must be at least 1");
    end

    // One extra bit so MODULUS == 2**WIDTH still yields a representable maximum.
    localparam logic [WIDTH:0]   MOD_MAX = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             step;
    logic             at_max;
    logic             at_zero;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (load),
        .step  (step)
    );

    assign at_max  = ({1'b0, count_q} == MOD_MAX);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = WIDTH'(clamp_to_mod(32'(load_val), MODULUS));
        end else if (step) begin
            case (up_dn)
                DIR_UP: begin
                    if (!at_max) begin
                        count_d = count_q + WIDTH'(1);
                    end else if (SATURATE == 0) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (!at_zero) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (SATURATE == 0) begin
                        count_d = TOP_VAL;
                        wrap_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= WIDTH'(RESET_VAL);
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = (up_dn == DIR_UP) ? at_max : at_zero;

endmodule
